// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants for the clock display scanner
package clock_pkg;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'd0,
        BLINK_SEC  = 2'd1,
        BLINK_MIN  = 2'd2,
        BLINK_HOUR = 2'd3
    } blink_sel_e;

    localparam logic [2:0] IDX_HOUR_T = 3'd0;
    localparam logic [2:0] IDX_HOUR_O = 3'd1;
    localparam logic [2:0] IDX_MIN_T  = 3'd2;
    localparam logic [2:0] IDX_MIN_O  = 3'd3;
    localparam logic [2:0] IDX_SEC_T  = 3'd4;
    localparam logic [2:0] IDX_SEC_O  = 3'd5;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// rtl/clock_display_scan_if.sv - time inputs and display pins of the scanner
interface clock_display_scan_if;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] blink_sel;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    modport master (output hour, min, sec, blink_sel, input an_n, seg_n, dp_n);
    modport slave  (input hour, min, sec, blink_sel, output an_n, seg_n, dp_n);
endinterface

// File: rtl/bin2bcd60.sv
// rtl/bin2bcd60.sv - 6-bit binary to two BCD digits with range flag
module bin2bcd60 #(
    parameter int LIMIT = 60
) (
    input  logic [5:0] val_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       oor_o
);

    assign oor_o = (val_i >= 6'(LIMIT));

    // Largest multiple of ten not above the value wins; covers 0..63
    always_comb begin
        tens_o = 4'd0;
        ones_o = 4'(val_i);
        for (int t = 6; t >= 1; t--) begin
            if (tens_o == 4'd0 && val_i >= 6'(t * 10)) begin
                tens_o = 4'(t);
                ones_o = 4'(val_i - 6'(t * 10));
            end
        end
    end

endmodule

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - six-digit multiplexed HH.MM.SS display driver
module clock_display_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clock_display_scan_if.slave  disp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [1:0]    sel_q;
    logic          first_q;
    logic [4:0]    hour_q;
    logic [5:0]    min_q, sec_q;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          pre_wrap, capture, hide, oor;
    logic [3:0]    dig;
    logic [1:0]    field;
    logic [3:0]    h_t, h_o, m_t, m_o, s_t, s_o;
    logic          h_oor, m_oor, s_oor;

    bin2bcd60 #(.LIMIT(24)) u_hour (.val_i({1'b0, hour_q}), .tens_o(h_t), .ones_o(h_o), .oor_o(h_oor));
    bin2bcd60 #(.LIMIT(60)) u_min  (.val_i(min_q),          .tens_o(m_t), .ones_o(m_o), .oor_o(m_oor));
    bin2bcd60 #(.LIMIT(60)) u_sec  (.val_i(sec_q),          .tens_o(s_t), .ones_o(s_o), .oor_o(s_oor));

    always_comb begin
        pre_wrap = (pre_q == PW'(SCAN_DIV - 1));
        pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
        idx_d    = idx_q;
        if (pre_wrap) begin
            idx_d = (idx_q == IDX_SEC_O) ? IDX_HOUR_T : idx_q + 3'd1;
        end
        // Whole frame comes from one snapshot, refreshed only at the 5->0 wrap
        capture = first_q || (pre_wrap && idx_q == IDX_SEC_O);

        // A new selection restarts the blink visible so the user sees the field at once
        if (disp.blink_sel != sel_q) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + 1'b1;
            phase_d = phase_q;
        end

        case (idx_q)
            IDX_HOUR_T: begin dig = h_t; oor = h_oor; end
            IDX_HOUR_O: begin dig = h_o; oor = h_oor; end
            IDX_MIN_T:  begin dig = m_t; oor = m_oor; end
            IDX_MIN_O:  begin dig = m_o; oor = m_oor; end
            IDX_SEC_T:  begin dig = s_t; oor = s_oor; end
            default:    begin dig = s_o; oor = s_oor; end
        endcase

        case (idx_q[2:1])
            2'd0:    field = BLINK_HOUR;
            2'd1:    field = BLINK_MIN;
            default: field = BLINK_SEC;
        endcase
        hide = !phase_q && (sel_q != BLINK_NONE) && (sel_q == field);

        an_d = 6'b111111;
        if (pre_q >= PW'(BLANK_CYC) && !hide) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d = oor ? SEG_DASH : glyph(dig);
        dp_d  = !(idx_q == IDX_HOUR_O || idx_q == IDX_MIN_O);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            idx_q   <= IDX_HOUR_T;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            sel_q   <= BLINK_NONE;
            first_q <= 1'b1;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            an_q    <= 6'b111111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            sel_q   <= disp.blink_sel;
            first_q <= 1'b0;
            if (capture) begin
                hour_q <= disp.hour;
                min_q  <= disp.min;
                sec_q  <= disp.sec;
            end
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign disp.an_n  = an_q;
    assign disp.seg_n = seg_q;
    assign disp.dp_n  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - directed bench for clock_display_scan
module tb_clock_display_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    clock_display_scan_if dif ();

    clock_display_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (dif)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_exp(input int d);
        case (d)
            0: glyph_exp = 7'h40;
            1: glyph_exp = 7'h79;
            2: glyph_exp = 7'h24;
            3: glyph_exp = 7'h30;
            4: glyph_exp = 7'h19;
            5: glyph_exp = 7'h12;
            6: glyph_exp = 7'h02;
            7: glyph_exp = 7'h78;
            8: glyph_exp = 7'h00;
            9: glyph_exp = 7'h10;
            default: glyph_exp = 7'h3F;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        dif.hour = 5'd0; dif.min = 6'd0; dif.sec = 6'd0; dif.blink_sel = 2'd0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (dif.an_n !== 6'h3F) begin n_fail++; $display("FAIL reset_an got=%b exp=%b", dif.an_n, 6'h3F); end
        n_checks++; if (dif.seg_n !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", dif.seg_n, 7'h7F); end
        n_checks++; if (dif.dp_n !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b exp=1", dif.dp_n); end
        n_checks++; if (dut.phase_q !== 1'b1 || dut.bcnt_q !== '0) begin n_fail++; $display("FAIL reset_blink got phase=%b bcnt=%0d exp phase=1 bcnt=0", dut.phase_q, dut.bcnt_q); end
    endtask

    task automatic test_steady();
        int dig[6] = '{1, 2, 3, 4, 5, 6};
        int pre, idx;
        logic [5:0] ea;
        dif.hour = 5'd12; dif.min = 6'd34; dif.sec = 6'd56;
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 48; k++) begin
            tick();
            pre = (cyc - 1) % 8;
            idx = ((cyc - 1) / 8) % 6;
            ea = (pre < 2) ? 6'h3F : ~(6'b1 << idx);
            n_checks++; if (dif.an_n !== ea) begin n_fail++; $display("FAIL steady_an cyc=%0d got=%b exp=%b", cyc, dif.an_n, ea); end
            n_checks++; if (dif.dp_n !== ((idx == 1 || idx == 3) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL steady_dp cyc=%0d got=%b idx=%0d", cyc, dif.dp_n, idx); end
            if (cyc > 1) begin
                n_checks++; if (dif.seg_n !== glyph_exp(dig[idx])) begin n_fail++; $display("FAIL steady_seg cyc=%0d got=%b exp=%b", cyc, dif.seg_n, glyph_exp(dig[idx])); end
            end
        end
    endtask

    task automatic test_tearing();
        int exp_d[2][6] = '{'{1, 2, 3, 4, 5, 9}, '{1, 2, 3, 5, 0, 0}};
        int pre, idx;
        logic [5:0] ea;
        dif.sec = 6'd59;
        for (int k = 0; k < 48; k++) tick();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 48; k++) begin
                if (f == 0 && k == 18) begin
                    dif.min = 6'd35; dif.sec = 6'd0;
                end
                tick();
                pre = k % 8;
                idx = k / 8;
                ea = (pre < 2) ? 6'h3F : ~(6'b1 << idx);
                n_checks++; if (dif.an_n !== ea) begin n_fail++; $display("FAIL tear_an frame=%0d k=%0d got=%b exp=%b", f, k, dif.an_n, ea); end
                n_checks++; if (dif.seg_n !== glyph_exp(exp_d[f][idx])) begin n_fail++; $display("FAIL tear_seg frame=%0d idx=%0d got=%b exp=%b", f, idx, dif.seg_n, glyph_exp(exp_d[f][idx])); end
            end
        end
    endtask

    task automatic test_out_of_range();
        int exp_d[6] = '{-1, -1, -1, -1, 0, 9};
        int idx;
        dif.hour = 5'd25; dif.min = 6'd60; dif.sec = 6'd9;
        for (int k = 0; k < 48; k++) tick();
        for (int k = 0; k < 48; k++) begin
            tick();
            idx = k / 8;
            n_checks++; if (dif.seg_n !== glyph_exp(exp_d[idx])) begin n_fail++; $display("FAIL oor_seg idx=%0d got=%b exp=%b", idx, dif.seg_n, glyph_exp(exp_d[idx])); end
        end
    endtask

    task automatic test_blink();
        int e0, m, pre, idx, c;
        bit hidden, found;
        logic [5:0] ea;
        dif.blink_sel = 2'd2;
        e0 = cyc + 1;
        for (int k = 0; k < 96; k++) begin
            tick();
            m = cyc - e0;
            pre = (cyc - 1) % 8;
            idx = ((cyc - 1) / 8) % 6;
            hidden = (m >= 1) && (((m - 1) / 32) % 2 == 1) && (idx == 2 || idx == 3);
            ea = (pre < 2 || hidden) ? 6'h3F : ~(6'b1 << idx);
            n_checks++; if (dif.an_n !== ea) begin n_fail++; $display("FAIL blink_an m=%0d idx=%0d got=%b exp=%b", m, idx, dif.an_n, ea); end
        end
        found = 0;
        for (int b = 0; b < 200 && !found; b++) begin
            c = cyc;
            m = cyc + 1 - e0;
            if ((((m - 1) / 32) % 2 == 1) && ((c / 8) % 6) < 2 && (c % 8) >= 2) found = 1;
            else tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL blink_find got=timeout exp=hidden hour slot");
        end else begin
            dif.blink_sel = 2'd3;
            idx = (cyc / 8) % 6;
            tick();
            ea = ~(6'b1 << idx);
            if (dif.an_n !== ea) begin n_fail++; $display("FAIL blink_switch_an got=%b exp=%b", dif.an_n, ea); end
            n_checks++; if (dut.bcnt_q !== '0 || dut.phase_q !== 1'b1) begin n_fail++; $display("FAIL blink_switch_state got bcnt=%0d phase=%b exp bcnt=0 phase=1", dut.bcnt_q, dut.phase_q); end
            for (int k = 0; k < 20; k++) begin
                tick();
                pre = (cyc - 1) % 8;
                idx = ((cyc - 1) / 8) % 6;
                ea = (pre < 2) ? 6'h3F : ~(6'b1 << idx);
                n_checks++; if (dif.an_n !== ea) begin n_fail++; $display("FAIL blink_after_an k=%0d got=%b exp=%b", k, dif.an_n, ea); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int dig[6] = '{1, 2, 3, 4, 5, 6};
        int pre, idx;
        bit found;
        logic [5:0] ea;
        found = 0;
        for (int b = 0; b < 60 && !found; b++) begin
            tick();
            if (((cyc - 1) / 8) % 6 == 4 && (cyc - 1) % 8 == 4) found = 1;
        end
        n_checks++; if (!found || dif.an_n !== 6'b101111) begin n_fail++; $display("FAIL mid_pre_an got=%b exp=%b", dif.an_n, 6'b101111); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dif.an_n !== 6'h3F) begin n_fail++; $display("FAIL mid_async_an got=%b exp=%b", dif.an_n, 6'h3F); end
        n_checks++; if (dif.seg_n !== 7'h7F || dif.dp_n !== 1'b1) begin n_fail++; $display("FAIL mid_async_seg got=%b/%b exp=1111111/1", dif.seg_n, dif.dp_n); end
        dif.hour = 5'd12; dif.min = 6'd34; dif.sec = 6'd56; dif.blink_sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 48; k++) begin
            tick();
            pre = (cyc - 1) % 8;
            idx = ((cyc - 1) / 8) % 6;
            ea = (pre < 2) ? 6'h3F : ~(6'b1 << idx);
            n_checks++; if (dif.an_n !== ea) begin n_fail++; $display("FAIL mid_restart_an cyc=%0d got=%b exp=%b", cyc, dif.an_n, ea); end
            if (cyc > 1) begin
                n_checks++; if (dif.seg_n !== glyph_exp(dig[idx])) begin n_fail++; $display("FAIL mid_restart_seg cyc=%0d got=%b exp=%b", cyc, dif.seg_n, glyph_exp(dig[idx])); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_steady();
        test_tearing();
        test_out_of_range();
        test_blink();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Downstream consumer of the hour/minute/second counters. Converts binary hour (0–23), minute and second (0–59) values to BCD, then time-multiplexes them onto a six-digit common-anode seven-segment display. Adds blinking of the field under adjustment and anti-ghosting blanking. Sits between the counter chain and the board pins.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot; must be ≥ 4.
- `BLANK_CYC`, default 2: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `BLINK_DIV`, default 12500000: clk cycles per blink half-period.
- `clk` in, 1: system clock, rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `hour` in, 5: binary hours.
- `min` in, 6: binary minutes.
- `sec` in, 6: binary seconds.
- `blink_sel` in, 2: field to blink.
  - 0: none
  - 1: seconds
  - 2: minutes
  - 3: hours
- `an_n` out, 6: digit enables, active-low; bit 0 is the leftmost digit (hour tens).
- `seg_n` out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp_n` out, 1: decimal point, active-low.

## Operation
- **Slot counting.**
  - Prescaler `pre` counts 0..`SCAN_DIV`-1.
  - At wrap, digit index `idx` advances 0→1→…→5→0.
- **Snapshot.**
  - `hour`, `min` and `sec` are captured into a snapshot register when `idx` wraps 5→0, and in the first cycle after reset release.
  - All six digits of one frame therefore come from a single coherent time value.
- **Digit map.**
  - idx 0/1: hour tens/ones.
  - idx 2/3: min tens/ones.
  - idx 4/5: sec tens/ones.
- **BCD conversion** uses a combinational compare-subtract (tens = value/10, ones = value%10), valid for 0–63.
- **Out-of-range values.** If the snapshot has hour > 23, or min/sec > 59, that field shows "--": `seg_n` = 7'b0111111, g segment only.
- **Glyphs.** Standard 0–9. Leading zeros are displayed, e.g. 7 shows "07".
- **Decimal point.** `dp_n` = 0 on idx 1 and idx 3 (separators), 1 elsewhere.
- **Blink.**
  - Counter `bcnt` counts 0..`BLINK_DIV`-1; `phase` toggles at each wrap.
  - `phase` = 1 means visible, 0 means hidden.
  - While hidden, the anodes of both digits of the selected field stay high (off).
  - Any change of `blink_sel` (detected against a registered copy) clears `bcnt` and sets `phase` = 1, so the selected field is shown immediately.
- **Blanking.** While `pre` < `BLANK_CYC`, `an_n` = 6'b111111; `seg_n` and `dp_n` already carry the new digit.

## Timing
- **Reset values (async, while `rst_n` = 0):**
  - `an_n` = 6'b111111, `seg_n` = 7'b1111111, `dp_n` = 1.
  - `pre` = 0, `idx` = 0, `bcnt` = 0, `phase` = 1, snapshot = 0.
- **Outputs** are registered, with one cycle of latency from the `pre`/`idx` state to the pins. First visible anode: cycle `BLANK_CYC`+1 after reset release.
- **Frame period** = 6×`SCAN_DIV` cycles. Input changes mid-frame appear at the next 5→0 wrap, never partially.
- **Simultaneous events:**
  - Snapshot capture and `blink_sel` change in the same cycle are independent; both take effect.
  - Blink wrap and `blink_sel` change in the same cycle: the change wins, giving `phase` = 1.
- **Reset mid-frame:** all outputs go dark immediately. Scanning restarts at idx 0 with a fresh snapshot.

## Structure
- Shared package `clock_pkg` holds:
  - the 7-segment glyph constants (0–9, DASH, BLANK);
  - the `blink_sel` encodings (BLINK_NONE/SEC/MIN/HOUR);
  - field index constants.
- Sub-module `bin2bcd60` (combinational: 6-bit in → 4-bit tens, 4-bit ones, out_of_range flag) is instantiated three times, with limit parameter 24 for hours and 60 for minutes/seconds.
- The top level holds the prescaler, index counter, snapshot register, blink logic and output registers.

## Test plan
- **Reset and steady display** (`SCAN_DIV`=8, `BLANK_CYC`=2): release reset with hour=12, min=34, sec=56.
  - Over one frame, `seg_n` shows 1,2,3,4,5,6 on `an_n` bits 0..5 in order.
  - `dp_n` is low on idx 1 and 3.
  - `an_n` is all-ones for the first 2 cycles of each slot.
- **Tearing:** change sec from 59 to 0 and min from 34 to 35 during idx 2.
  - The current frame shows 34:59.
  - The next frame shows 35:00.
- **Out-of-range:** hour=25, min=60, sec=9 → display "--" "--" "09".
- **Blink** (`BLINK_DIV`=32): with `blink_sel`=2, the min digits' anodes are off in alternate 32-cycle windows; the hour and sec digits are never suppressed. Switch `blink_sel` to 3 while `phase` is hidden → the hour digits are visible in the next cycle and `bcnt` = 0.
- **Reset mid-frame:** assert `rst_n`=0 at idx 4.
  - Outputs go to all-ones asynchronously, without waiting for a clock edge.
  - After release, scanning restarts at idx 0.
